// File: rtl/mnist_nn_key_debounce_pkg.sv
// Shared types and default constants for the key debounce block.
// The optional press-latch feature is enabled by KEY_DEBOUNCE_PRESS_LATCH_EN.
package mnist_nn_key_pkg;

    typedef enum logic {
        KEY_STABLE  = 1'b0,
        KEY_PENDING = 1'b1
    } key_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 20;

    // Pins are active-low, so the idle (released) level is 1.
    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/mnist_nn_key_debounce_ch.sv
// Single key channel: synchronizer, STABLE/PENDING debounce FSM and strobes.
// press_set_o is the next-state press strobe, used by the optional latch.
module mnist_nn_key_debounce_ch
    import mnist_nn_key_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_i,
    output logic key_o,
    output logic press_o,
    output logic release_o,
    output logic press_set_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    key_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   key_q, key_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   sync_lvl;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], key_i};
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{KEY_RELEASED}};
            state_q <= KEY_STABLE;
            cnt_q   <= '0;
            key_q   <= KEY_RELEASED;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            KEY_STABLE: begin
                if (sync_lvl != key_q) begin
                    state_d = KEY_PENDING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            KEY_PENDING: begin
                if (sync_lvl == key_q) begin
                    state_d = KEY_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Counter stops here, so it can never wrap.
                    state_d = KEY_STABLE;
                    cnt_d   = '0;
                    key_d   = sync_lvl;
                    if (sync_lvl == 1'b0) press_d = 1'b1;
                    else                  rel_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = KEY_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_o       = key_q;
    assign press_o     = press_q;
    assign release_o   = rel_q;
    assign press_set_o = press_d;

endmodule

// File: rtl/mnist_nn_key_debounce.sv
// Debounces NUM_KEYS active-low push-buttons for the key PIO in_port.
// Sticky press flags are built only when KEY_DEBOUNCE_PRESS_LATCH_EN is defined.
module mnist_nn_key_debounce
    import mnist_nn_key_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    input  logic [NUM_KEYS-1:0] latch_clr,
    output logic [NUM_KEYS-1:0] press_latched
);

    logic [NUM_KEYS-1:0] press_set;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        mnist_nn_key_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .key_i      (key_in[k]),
            .key_o      (key_out[k]),
            .press_o    (press_pulse[k]),
            .release_o  (release_pulse[k]),
            .press_set_o(press_set[k])
        );
    end

`ifdef KEY_DEBOUNCE_PRESS_LATCH_EN
    logic [NUM_KEYS-1:0] latch_q, latch_d;

    // A press on the same edge as a clear keeps the flag set.
    assign latch_d = (latch_q & ~latch_clr) | press_set;

    always_ff @(posedge clk) begin
        if (!reset_n) latch_q <= '0;
        else          latch_q <= latch_d;
    end

    assign press_latched = latch_q;
`else
    logic unused_latch;
    assign unused_latch  = ^{latch_clr, press_set};
    assign press_latched = '0;
`endif

endmodule

// File: tb/tb_mnist_nn_key_debounce.sv
// Directed, table-driven bench for mnist_nn_key_debounce (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_mnist_nn_key_debounce;

`ifdef KEY_DEBOUNCE_PRESS_LATCH_EN
    localparam logic [1:0] LMASK = 2'b11;
`else
    localparam logic [1:0] LMASK = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] key_in, latch_clr;
    logic [1:0] key_out, press_pulse, release_pulse, press_latched;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mnist_nn_key_debounce #(
        .NUM_KEYS       (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_in       (key_in),
        .key_out      (key_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .latch_clr    (latch_clr),
        .press_latched(press_latched)
    );

    typedef struct {
        logic       rst_n;
        logic [1:0] key;
        logic [1:0] clr;
        logic [1:0] out;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, logic r, logic [1:0] k, logic [1:0] c,
                                logic [1:0] o, logic [1:0] p, logic [1:0] rl,
                                logic [1:0] lt);
        vec_t v;
        v.rst_n = r; v.key = k; v.clr = c; v.out = o;
        v.pr = p; v.rl = rl; v.lat = lt & LMASK;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int row, input logic [1:0] act,
                       input logic [1:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        else
            n_pass++;
    endtask

    initial begin
        int edges;
        reset_n   = 1'b0;
        key_in    = 2'b11;
        latch_clr = 2'b00;

        // Reset with keys held pressed, then press accepted after full latency.
        add(3, 0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11);
        add(1, 1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        // Clean press and release on key0.
        add(1, 0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(2, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01);
        add(1, 1, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        // Bounce: low 3, high 1, low held.
        add(3, 1, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01);
        add(1, 1, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        // Simultaneous keys.
        add(5, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11);
        add(1, 1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        // Reset mid-count discards the pending press.
        add(2, 1, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 0, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01);
        add(1, 1, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00);
        // Press latch: persist, clear, and set-wins-over-clear.
        add(1, 0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10);
        add(2, 1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10);
        add(1, 1, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00);
        add(1, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        add(5, 1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 1, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10);
        add(2, 1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n   = vecs[i].rst_n;
            key_in    = vecs[i].key;
            latch_clr = vecs[i].clr;
            @(posedge clk);
            #1;
            chk("key_out",       i, key_out,       vecs[i].out);
            chk("press_pulse",   i, press_pulse,   vecs[i].pr);
            chk("release_pulse", i, release_pulse, vecs[i].rl);
            chk("press_latched", i, press_latched, vecs[i].lat);
        end

        // Measured latency of a clean key0 press, bounded wait.
        @(negedge clk);
        reset_n = 1'b0; key_in = 2'b11; latch_clr = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        key_in = 2'b10;
        edges = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (key_out[0] == 1'b0) begin
                edges = n;
                break;
            end
        end
        n_total++;
        if (edges != 6)
            $display("FAIL latency: got %0d edges expected 6 (0 = timeout)", edges);
        else
            n_pass++;
        chk("latency_press", 0, press_pulse, (edges == 6) ? 2'b01 : 2'bxx);
        @(posedge clk);
        #1;
        chk("latency_strobe_end", 0, press_pulse, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
